// File: rtl/arbiter_rr_param.sv
// Round-robin output-port arbiter with RTS/DCTS flow control and a bounded-burst
// fairness limit; one instance per router output port.
module arbiter_rr_param #(
  parameter  int NUM_PORTS = 5,
  parameter  int MAX_HOLD  = 8,
  localparam int HCW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1,
  localparam int IW        = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts,
  output logic                 busy,
  output logic                 dbg_state_o,
  output logic [IW-1:0]        dbg_cur_o,
  output logic [HCW-1:0]       dbg_hold_o
);

  // Handshake: rts is offered by this block and held until taken; a transfer
  // occurs on every rising edge where rts && dcts, after which rts drops for one
  // turnaround cycle. While rts && !dcts, all arbitration state is frozen.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

  state_e         st_q, st_d;
  logic [IW-1:0]  cur_q, cur_d;
  logic           rts_q, rts_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic           xfer;
  logic           upd;
  logic           hold_ok;
  logic           low_found;
  logic [IW-1:0]  low_idx;
  logic           rr_found;
  logic [IW-1:0]  rr_idx;
  logic [IW-1:0]  scan_j;

  assign xfer = rts_q & dcts;
  assign upd  = ~(rts_q & ~dcts);

  // low_* picks the lowest requester; rr_* the first requester after cur_q,
  // excluding cur_q itself (iterating downward leaves the nearest one).
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[IW'(i)]) begin
        low_found = 1'b1;
        low_idx   = IW'(i);
      end
    end
    rr_found = 1'b0;
    rr_idx   = cur_q;
    scan_j   = '0;
    for (int i = NUM_PORTS - 1; i >= 1; i--) begin
      scan_j = IW'((int'(cur_q) + i) % NUM_PORTS);
      if (req[scan_j]) begin
        rr_found = 1'b1;
        rr_idx   = scan_j;
      end
    end
  end

  // The burst limit is enforced on the transfer edge, so the current owner keeps
  // the port through its turnaround cycle and completes exactly MAX_HOLD transfers.
  assign hold_ok = (MAX_HOLD == 0) || !xfer || (hold_q < HOLD_LAST);

  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    unique case (st_q)
      ST_IDLE: begin
        if (low_found) begin
          st_d  = ST_SERVE;
          cur_d = low_idx;
        end
      end
      ST_SERVE: begin
        if (req[cur_q] && hold_ok) begin
          cur_d = cur_q;
        end else if (rr_found) begin
          cur_d = rr_idx;
        end else if (!req[cur_q]) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rts_d = 1'b1;
    if (st_q == ST_IDLE || xfer) begin
      rts_d = 1'b0;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (upd) begin
      if (xfer) begin
        if (st_d == ST_SERVE && cur_d == cur_q) begin
          hold_d = (hold_q >= HOLD_LAST) ? hold_q : hold_q + HCW'(1);
        end else begin
          hold_d = '0;
        end
      end else if (st_d != st_q || cur_d != cur_q) begin
        hold_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_IDLE;
      cur_q  <= '0;
      rts_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      rts_q <= rts_d;
      if (upd) begin
        st_q   <= st_d;
        cur_q  <= cur_d;
        hold_q <= hold_d;
      end
    end
  end

  always_comb begin
    xbar_sel = '0;
    if (st_q == ST_SERVE) begin
      xbar_sel[cur_q] = 1'b1;
    end
  end

  assign grant       = xbar_sel & {NUM_PORTS{xfer}};
  assign rts         = rts_q;
  assign busy        = (st_q == ST_SERVE);
  assign dbg_state_o = st_q;
  assign dbg_cur_o   = cur_q;
  assign dbg_hold_o  = hold_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
  a_no_idle_grant : assert property (@(posedge clk) disable iff (!rst) !busy |-> grant == '0);
  a_stall_freeze : assert property (@(posedge clk) disable iff (!rst)
    (rts_q && !dcts) |=> (rts_q && $stable(cur_q) && $stable(st_q) && $stable(hold_q)));

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Directed bench for arbiter_rr_param (5 ports, burst limit 4): expected grant
// strobes are queued as stimulus is applied and popped when the DUT strobes.
module tb_arbiter_rr_param;

  localparam int NP  = 5;
  localparam int MH  = 4;
  localparam int HCW = $clog2(MH + 1);
  localparam int IW  = $clog2(NP);

  logic           clk;
  logic           rst;
  logic [NP-1:0]  req;
  logic           dcts;
  logic [NP-1:0]  grant;
  logic [NP-1:0]  xbar_sel;
  logic           rts;
  logic           busy;
  logic           dbg_state;
  logic [IW-1:0]  dbg_cur;
  logic [HCW-1:0] dbg_hold;

  logic [NP-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  arbiter_rr_param #(.NUM_PORTS(NP), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .dcts(dcts),
    .grant(grant), .xbar_sel(xbar_sel), .rts(rts), .busy(busy),
    .dbg_state_o(dbg_state), .dbg_cur_o(dbg_cur), .dbg_hold_o(dbg_hold)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Sample at the falling edge; every grant strobe is matched against the queue.
  task automatic half();
    @(negedge clk);
    if (!busy) check("idle_no_grant", 32'(grant), 32'd0);
    if (grant != '0) begin
      check("grant_onehot", 32'($countones(grant)), 32'd1);
      if (exp_q.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
      else check("grant_seq", 32'(grant), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    req  = '0;
    dcts = 1'b1;
    #2 rst = 1'b0;

    half();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_xbar", 32'(xbar_sel), 32'd0);
    check("rst_rts", 32'(rts), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(dbg_hold), 32'd0);
    half();
    rst = 1'b1;
    adv();
    repeat ($urandom_range(1, 3)) begin
      half();
      check("idle_busy", 32'(busy), 32'd0);
      adv();
    end

    // single requester, port 2: grant every other cycle from 2 cycles after sampling
    req = 5'b00100;
    repeat (5) exp_q.push_back(5'b00100);
    adv();
    for (int i = 0; i < 10; i++) begin
      half();
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_xbar", 32'(xbar_sel), 32'h04);
      check("t1_rts", 32'(rts), 32'(i % 2));
      check("t1_grant", 32'(grant), (i % 2 == 1) ? 32'h04 : 32'h00);
      if (i == 9) req = '0;
      adv();
    end
    half();
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_rts", 32'(rts), 32'd0);
    check("t1_idle_xbar", 32'(xbar_sel), 32'd0);
    adv();

    // contention between ports 1 and 3: bursts of exactly MAX_HOLD
    req = 5'b01010;
    repeat (MH) exp_q.push_back(5'b00010);
    repeat (MH) exp_q.push_back(5'b01000);
    repeat (MH) exp_q.push_back(5'b00010);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      half();
      if (exp_q.size() == 0) req = '0;
      adv();
    end
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    req = '0;
    half();
    check("t2_idle", 32'(busy), 32'd0);
    adv();

    // lone requester on port 1: no burst limit, hold counter saturates
    req = 5'b00010;
    repeat (10) exp_q.push_back(5'b00010);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      half();
      adv();
    end
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    half();
    check("t3_hold_sat", 32'(dbg_hold), 32'(MH - 1));
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_rts", 32'(rts), 32'd0);
    dcts = 1'b0;
    adv();

    // downstream stall while rts is offered
    for (int i = 0; i < 5; i++) begin
      half();
      check("t4_stall_rts", 32'(rts), 32'd1);
      check("t4_stall_grant", 32'(grant), 32'd0);
      check("t4_stall_xbar", 32'(xbar_sel), 32'h02);
      check("t4_stall_hold", 32'(dbg_hold), 32'(MH - 1));
      adv();
    end
    exp_q.push_back(5'b00010);
    dcts = 1'b1;
    half();
    check("t4_release_grant", 32'(grant), 32'h02);
    check("t4_release_rts", 32'(rts), 32'd1);
    adv();
    half();
    check("t4_turnaround_rts", 32'(rts), 32'd0);
    req = '0;
    n = 0;
    do begin
      adv();
      half();
      n++;
    end while ((busy || rts) && n < 10);
    check("t4_to_idle", {30'd0, busy, rts}, 32'd0);
    adv();

    // wrap-around from port 4 to port 0
    req = 5'b10000;
    exp_q.push_back(5'b10000);
    adv();
    half();
    check("t5_xbar4", 32'(xbar_sel), 32'h10);
    check("t5_rts0", 32'(rts), 32'd0);
    adv();
    half();
    check("t5_grant4", 32'(grant), 32'h10);
    req = 5'b00001;
    exp_q.push_back(5'b00001);
    adv();
    half();
    check("t5_wrap_xbar", 32'(xbar_sel), 32'h01);
    check("t5_wrap_rts", 32'(rts), 32'd0);
    check("t5_wrap_grant", 32'(grant), 32'd0);
    adv();
    half();
    check("t5_grant0", 32'(grant), 32'h01);
    req = '0;
    adv();
    half();
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_rts", 32'(rts), 32'd0);
    check("t5_idle_xbar", 32'(xbar_sel), 32'd0);
    adv();

    // asynchronous reset in the middle of a grant
    req = 5'b00001;
    exp_q.push_back(5'b00001);
    adv();
    half();
    adv();
    half();
    check("t6_pre_grant", 32'(grant), 32'h01);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_rts", 32'(rts), 32'd0);
    check("t6_rst_xbar", 32'(xbar_sel), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    half();
    check("t6_in_reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    adv();
    half();
    check("t6_first_busy", 32'(busy), 32'd1);
    check("t6_first_rts", 32'(rts), 32'd0);
    check("t6_first_grant", 32'(grant), 32'd0);
    exp_q.push_back(5'b00001);
    adv();
    half();
    check("t6_grant", 32'(grant), 32'h01);
    check("t6_grant_rts", 32'(rts), 32'd1);
    req = '0;
    adv();
    half();
    check("t6_end_idle", 32'(busy), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
